// File: rtl/pdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pdm_pkg
//  Description : Shared definitions for the PDM-to-PCM decimator:
//                default PCM width, PCM sample type, CIC accumulator width
//                computation and output saturation limits.
//  Revision    : 1.0  initial release
// ============================================================================
package pdm_pkg;

    // Default signed PCM output width.
    localparam int PCM_W_DEF = 16;

    typedef logic signed [PCM_W_DEF-1:0] pcm_t;

    // Saturation limits for the default PCM width.
    localparam pcm_t PCM_MAX = 16'sh7FFF;
    localparam pcm_t PCM_MIN = 16'sh8000;

    // CIC register growth: ORDER*LOG2R bits of gain, plus one bit for the
    // +/-1 input and one more so that the +R^N full-scale peak still fits
    // as a positive two's complement value.
    function automatic int acc_width(input int order, input int log2r);
        return order * log2r + 2;
    endfunction

    // Largest positive value of a signed w-bit word.
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Most negative value of a signed w-bit word.
    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage : pdm_pkg
`default_nettype wire

// File: rtl/pdm_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : pdm_sync_2ff
//  Description : Two-flop synchronizer for an asynchronous single-bit input.
//                Clocked every cycle (no enable); both stages reset to 0.
//  Ports       : clk    - system clock
//                rst_n  - asynchronous active-low reset
//                d_i    - asynchronous input bit
//                q_o    - synchronized output bit (2 cycles of latency)
//  Revision    : 1.0  initial release
// ============================================================================
module pdm_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : pdm_sync_2ff
`default_nettype wire

// File: rtl/pdm_decimator.sv
`default_nettype none
// ============================================================================
//  Module      : pdm_decimator
//  Description : 1-bit PDM stream to signed PCM converter. CIC (Sinc^ORDER)
//                decimator with ratio R = 2**LOG2R, saturating output
//                scaling and a one-cycle sample-valid strobe.
//  Parameters  : LOG2R  - log2 of the decimation ratio
//                ORDER  - number of integrator/comb stages (1..4)
//                PCM_W  - output sample width (signed)
//  Ports       : clk       - system clock, one PDM bit per enabled cycle
//                rst_n     - asynchronous active-low reset
//                ena       - clock enable; low freezes all filter state
//                pdm_in    - PDM bit, 1 = +1, 0 = -1
//                pcm_out   - decimated sample, held between strobes
//                pcm_valid - one-cycle pulse when pcm_out updates
//  Options     : PDM_DECIM_SYNC_EN - when defined, pdm_in passes through a
//                2-flop synchronizer before use (2 cycles extra latency).
//  Revision    : 1.0  initial release
// ============================================================================
module pdm_decimator
    import pdm_pkg::*;
#(
    parameter int LOG2R = 6,
    parameter int ORDER = 3,
    parameter int PCM_W = PCM_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    pdm_in,
    output logic signed [PCM_W-1:0] pcm_out,
    output logic                    pcm_valid
);

    localparam int ACC_W = acc_width(ORDER, LOG2R);
    // Right shift that maps the CIC gain R^ORDER onto the PCM full scale.
    localparam int SHIFT = ORDER * LOG2R - (PCM_W - 1);
    // Scaling width wide enough for either shift direction without loss.
    localparam int SCL_W = ACC_W + PCM_W;

    localparam logic [LOG2R-1:0]        CNT_LAST = '1;
    localparam logic signed [SCL_W-1:0] SAT_HI   = SCL_W'(sat_max(PCM_W));
    localparam logic signed [SCL_W-1:0] SAT_LO   = SCL_W'(sat_min(PCM_W));

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic pdm_bit_w;

`ifdef PDM_DECIM_SYNC_EN
    pdm_sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pdm_in),
        .q_o   (pdm_bit_w)
    );
`else
    assign pdm_bit_w = pdm_in;
`endif

    // 1 -> +1 (0...01), 0 -> -1 (1...11)
    logic [ACC_W-1:0] x_w;
    assign x_w = {{(ACC_W-1){~pdm_bit_w}}, 1'b1};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ORDER-1:0][ACC_W-1:0] integ_q;
    logic [ORDER-1:0][ACC_W-1:0] integ_d;
    logic [ORDER-1:0][ACC_W-1:0] dly_q;
    logic [LOG2R-1:0]            cnt_q;
    logic [LOG2R-1:0]            cnt_d;
    logic signed [PCM_W-1:0]     pcm_q;
    logic signed [PCM_W-1:0]     pcm_d;
    logic                        valid_q;
    logic                        dec_w;

    assign cnt_d = cnt_q + LOG2R'(1);
    assign dec_w = ena && (cnt_q == CNT_LAST);

    // ------------------------------------------------------------------
    // Integrators: each stage adds the previous stage's registered value,
    // which pipelines the chain. Wrap-around is intentional; the combs
    // cancel it as long as the true output fits in ACC_W bits.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < ORDER; k++) begin : g_integ
        if (k == 0) begin : g_first
            assign integ_d[k] = integ_q[k] + x_w;
        end else begin : g_next
            assign integ_d[k] = integ_q[k] + integ_q[k-1];
        end
    end

    // ------------------------------------------------------------------
    // Comb chain, evaluated only at the decimation edge. comb_w[k] is the
    // input of comb stage k and the value that stage's delay captures.
    // ------------------------------------------------------------------
    logic [ORDER:0][ACC_W-1:0] comb_w;

    assign comb_w[0] = integ_q[ORDER-1];

    for (genvar k = 0; k < ORDER; k++) begin : g_comb
        assign comb_w[k+1] = comb_w[k] - dly_q[k];
    end

    // ------------------------------------------------------------------
    // Output scaling and saturation
    // ------------------------------------------------------------------
    logic signed [SCL_W-1:0] comb_ext_w;
    logic signed [SCL_W-1:0] scaled_w;

    assign comb_ext_w = {{PCM_W{comb_w[ORDER][ACC_W-1]}}, comb_w[ORDER]};

    if (SHIFT >= 0) begin : g_shr
        assign scaled_w = comb_ext_w >>> SHIFT;
    end else begin : g_shl
        assign scaled_w = comb_ext_w <<< (-SHIFT);
    end

    // Only the positive full-scale peak (+R^N) can exceed the range in a
    // well-formed stream; both clamps are kept for arbitrary parameters.
    always_comb begin
        pcm_d = scaled_w[PCM_W-1:0];
        if (scaled_w > SAT_HI) begin
            pcm_d = SAT_HI[PCM_W-1:0];
        end else if (scaled_w < SAT_LO) begin
            pcm_d = SAT_LO[PCM_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ_q <= '0;
            dly_q   <= '0;
            cnt_q   <= '0;
            pcm_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= dec_w;
            if (ena) begin
                integ_q <= integ_d;
                cnt_q   <= cnt_d;
            end
            if (dec_w) begin
                dly_q <= comb_w[ORDER-1:0];
                pcm_q <= pcm_d;
            end
        end
    end

    assign pcm_out   = pcm_q;
    assign pcm_valid = valid_q;

endmodule : pdm_decimator
`default_nettype wire
